// File: rtl/argmax_stream.sv
// rtl/argmax_stream.sv - streaming arg-max with runner-up margin and low-confidence flag
module argmax_stream #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 12,
  localparam int IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  input  logic [DATA_W:0]   margin_thresh,
  output logic              busy,
  output logic              valid_out,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] max_score,
  output logic [DATA_W:0]   margin,
  output logic              low_conf
);

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

  logic [IDX_W-1:0]         cnt;
  logic signed [DATA_W-1:0] run_max;
  logic signed [DATA_W-1:0] run_2nd;
  logic [IDX_W-1:0]         run_idx;
  logic [DATA_W:0]          thr_q;

  logic signed [DATA_W-1:0] score;
  logic                     first;
  logic                     last;
  logic                     accept;
  logic signed [DATA_W-1:0] nxt_max;
  logic signed [DATA_W-1:0] nxt_2nd;
  logic [IDX_W-1:0]         nxt_idx;
  logic [DATA_W:0]          nxt_margin;

  // Fold the incoming score into the running top-1/top-2; ties keep the earlier index.
  always_comb begin
    score   = $signed(data_in);
    first   = (cnt == '0);
    last    = (cnt == LAST_IDX);
    accept  = valid_in && !flush;
    nxt_max = run_max;
    nxt_2nd = run_2nd;
    nxt_idx = run_idx;
    if (first) begin
      nxt_max = score;
      nxt_idx = '0;
      nxt_2nd = MIN_VAL;
    end else if (score > run_max) begin
      nxt_2nd = run_max;
      nxt_max = score;
      nxt_idx = cnt;
    end else if (score > run_2nd) begin
      nxt_2nd = score;
    end
    // One extra bit keeps max - runner-up non-negative and overflow-free.
    nxt_margin = {nxt_max[DATA_W-1], nxt_max} - {nxt_2nd[DATA_W-1], nxt_2nd};
  end

  // Frame position and running state; flush abandons the partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      busy    <= 1'b0;
      run_max <= '0;
      run_2nd <= '0;
      run_idx <= '0;
    end else if (flush) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (valid_in) begin
      run_max <= nxt_max;
      run_2nd <= nxt_2nd;
      run_idx <= nxt_idx;
      if (last) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        cnt  <= cnt + 1'b1;
        busy <= 1'b1;
      end
    end
  end

  // Result registers load only on an accepted last score and otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      class_idx <= '0;
      max_score <= '0;
      margin    <= '0;
      thr_q     <= '0;
    end else begin
      valid_out <= 1'b0;
      if (accept && last) begin
        valid_out <= 1'b1;
        class_idx <= nxt_idx;
        max_score <= nxt_max;
        margin    <= nxt_margin;
        thr_q     <= margin_thresh;
      end
    end
  end

  // Threshold is captured alongside the margin, so the flag holds with the result.
  assign low_conf = (margin < thr_q);

endmodule

// File: tb/tb_argmax_stream.sv
// tb/tb_argmax_stream.sv - self-checking bench for argmax_stream
module tb_argmax_stream;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  bit   cmp_en;

  // main instance: 10 classes, 12-bit scores
  logic        v, fl;
  logic [11:0] d;
  logic [12:0] th;
  logic        busy, valid_out, low_conf;
  logic [3:0]  class_idx;
  logic [11:0] max_score;
  logic [12:0] margin;

  // single-class instance, 8-bit scores
  logic        v1, fl1;
  logic [7:0]  d1;
  logic [8:0]  th1;
  logic        busy1, valid_out1, low_conf1;
  logic [0:0]  class_idx1;
  logic [7:0]  max_score1;
  logic [8:0]  margin1;

  // 16-class instance, 16-bit scores
  logic        v2, fl2;
  logic [15:0] d2;
  logic [16:0] th2;
  logic        busy2, valid_out2, low_conf2;
  logic [3:0]  class_idx2;
  logic [15:0] max_score2;
  logic [16:0] margin2;

  argmax_stream #(.NUM_CLASSES(10), .DATA_W(12)) u0 (
    .clk(clk), .rst_n(rst_n), .valid_in(v), .data_in(d), .flush(fl),
    .margin_thresh(th), .busy(busy), .valid_out(valid_out),
    .class_idx(class_idx), .max_score(max_score), .margin(margin), .low_conf(low_conf));

  argmax_stream #(.NUM_CLASSES(1), .DATA_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .valid_in(v1), .data_in(d1), .flush(fl1),
    .margin_thresh(th1), .busy(busy1), .valid_out(valid_out1),
    .class_idx(class_idx1), .max_score(max_score1), .margin(margin1), .low_conf(low_conf1));

  argmax_stream #(.NUM_CLASSES(16), .DATA_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .valid_in(v2), .data_in(d2), .flush(fl2),
    .margin_thresh(th2), .busy(busy2), .valid_out(valid_out2),
    .class_idx(class_idx2), .max_score(max_score2), .margin(margin2), .low_conf(low_conf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arg-max: first index holding the largest value; runner-up is the
  // largest of the remaining elements (most-negative value when there are none).
  function automatic void ref_eval(input int a[16], input int n, input int w,
                                   output int idx, output int mx, output int mg);
    int second;
    idx = 0;
    for (int i = 1; i < n; i++) if (a[i] > a[idx]) idx = i;
    mx = a[idx];
    second = -(1 << (w - 1));
    for (int i = 0; i < n; i++) if (i != idx && a[i] > second) second = a[i];
    mg = mx - second;
  endfunction

  // Frame-level model of the main instance, advanced on each clock edge.
  int mbuf[16];
  int m_n, m_idx, m_max, m_margin;
  bit m_valid, m_busy, m_low;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n = 0; m_valid = 0; m_busy = 0;
      m_idx = 0; m_max = 0; m_margin = 0; m_low = 0;
    end else begin
      m_valid = 0;
      if (fl) begin
        m_n = 0;
      end else if (v) begin
        mbuf[m_n] = int'($signed(d));
        m_n++;
        if (m_n == 10) begin
          ref_eval(mbuf, 10, 12, m_idx, m_max, m_margin);
          m_low   = (m_margin < int'(th));
          m_valid = 1;
          m_n     = 0;
        end
      end
      m_busy = (m_n != 0);
    end
  end

  int pulse_cyc[$];
  int pulse_idx[$];
  int pulse_max[$];

  // Compare the main instance against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid_out", int'(valid_out), int'(m_valid));
      check("busy", int'(busy), int'(m_busy));
      check("class_idx", int'(class_idx), m_idx);
      check("max_score", int'($signed(max_score)), m_max);
      check("margin", int'(margin), m_margin);
      check("low_conf", int'(low_conf), int'(m_low));
      if (valid_out) begin
        pulse_cyc.push_back(cyc);
        pulse_idx.push_back(int'(class_idx));
        pulse_max.push_back(int'($signed(max_score)));
      end
    end
  end

  task automatic step(input logic vv, input int dd, input logic ff);
    v  = vv;
    d  = dd[11:0];
    fl = ff;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int f[10], input int gap_max, input int n);
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step(1'b0, 0, 1'b0);
      step(1'b1, f[i], 1'b0);
    end
    v = 1'b0;
  endtask

  task automatic clear_pulses();
    pulse_cyc.delete();
    pulse_idx.delete();
    pulse_max.delete();
  endtask

  int f1[10] = '{3, -7, 100, 45, 99, 0, -2048, 12, 100, 5};
  int f2[10];
  int f3[10] = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
  int f4[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 77};
  int f5[10] = '{0, 60, -1, 2, 3, 59, 4, 5, 6, 7};
  int f6[10] = '{90, 1, 2, 3, 4, 5, 6, 7, 8, 89};
  int a[16];
  int ei, em, eg, tv;
  logic signed [15:0] r16;

  initial begin
    rst_n = 1'b0; v = 0; d = '0; fl = 0; th = '0;
    v1 = 0; d1 = '0; fl1 = 0; th1 = '0;
    v2 = 0; d2 = '0; fl2 = 0; th2 = '0;
    checks = 0; errors = 0; cmp_en = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp_en = 1;
    check("rst_valid", int'(valid_out), 0);
    check("rst_idx", int'(class_idx), 0);
    check("rst_margin", int'(margin), 0);
    check("rst_low", int'(low_conf), 0);
    rst_n = 1'b1;
    step(1'b0, 0, 1'b0);

    // tie on the maximum: earlier index wins, margin 0
    th = 13'd10;
    send_frame(f1, 0, 10);
    check("f1_valid", int'(valid_out), 1);
    check("f1_idx", int'(class_idx), 2);
    check("f1_max", int'($signed(max_score)), 100);
    check("f1_margin", int'(margin), 0);
    check("f1_low", int'(low_conf), 1);

    for (int i = 0; i < 10; i++) f2[i] = (i == 7) ? 20 : -5;
    send_frame(f2, 0, 10);
    check("f2_idx", int'(class_idx), 7);
    check("f2_margin", int'(margin), 25);
    repeat (5) step(1'b0, 0, 1'b0);
    check("f2_hold_valid", int'(valid_out), 0);
    check("f2_hold_idx", int'(class_idx), 7);
    check("f2_hold_max", int'($signed(max_score)), 20);
    check("f2_hold_low", int'(low_conf), 0);

    // back-to-back frames, then the same frames with random gaps
    clear_pulses();
    send_frame(f3, 0, 10);
    send_frame(f4, 0, 10);
    step(1'b0, 0, 1'b0);
    check("b2b_pulses", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2) begin
      check("b2b_spacing", pulse_cyc[1] - pulse_cyc[0], 10);
      check("b2b_idx0", pulse_idx[0], 4);
      check("b2b_idx1", pulse_idx[1], 9);
    end
    clear_pulses();
    send_frame(f3, 3, 10);
    send_frame(f4, 3, 10);
    step(1'b0, 0, 1'b0);
    check("gap_pulses", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2) begin
      check("gap_idx0", pulse_idx[0], 4);
      check("gap_idx1", pulse_idx[1], 9);
      check("gap_max0", pulse_max[0], 50);
      check("gap_max1", pulse_max[1], 77);
    end

    // flush mid-frame, previous result held, then a clean frame
    clear_pulses();
    send_frame(f1, 0, 6);
    step(1'b0, 0, 1'b1);
    fl = 1'b0;
    check("flush_busy", int'(busy), 0);
    check("flush_hold_idx", int'(class_idx), 9);
    send_frame(f5, 0, 10);
    step(1'b0, 0, 1'b0);
    check("flush_pulses", pulse_cyc.size(), 1);
    if (pulse_idx.size() == 1) check("flush_idx", pulse_idx[0], 1);

    // flush coincident with the last score suppresses the result
    clear_pulses();
    send_frame(f4, 0, 9);
    step(1'b1, f4[9], 1'b1);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    check("flush_last_pulses", pulse_cyc.size(), 0);
    check("flush_last_idx", int'(class_idx), 1);

    // reset mid-frame clears outputs; next frame starts at class 0
    clear_pulses();
    send_frame(f3, 0, 4);
    rst_n = 1'b0;
    step(1'b0, 0, 1'b0);
    rst_n = 1'b1;
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_idx", int'(class_idx), 0);
    check("rstmid_max", int'(max_score), 0);
    check("rstmid_margin", int'(margin), 0);
    check("rstmid_low", int'(low_conf), 0);
    th = 13'd0;
    send_frame(f6, 0, 10);
    check("f6_idx", int'(class_idx), 0);
    check("f6_margin", int'(margin), 1);
    step(1'b0, 0, 1'b0);
    check("rstmid_pulses", pulse_cyc.size(), 1);

    // single-class instance
    th1 = 9'd0; d1 = 8'h80; v1 = 1'b1;
    @(posedge clk); #1;
    check("n1_valid", int'(valid_out1), 1);
    check("n1_idx", int'(class_idx1), 0);
    check("n1_max", int'($signed(max_score1)), -128);
    check("n1_margin", int'(margin1), 0);
    check("n1_low", int'(low_conf1), 0);
    th1 = 9'd256; d1 = 8'h7f;
    @(posedge clk); #1;
    v1 = 1'b0;
    check("n1b_margin", int'(margin1), 255);
    check("n1b_low", int'(low_conf1), 1);
    check("n1_busy", int'(busy1), 0);
    @(posedge clk); #1;
    check("n1_idle_valid", int'(valid_out1), 0);

    // 16-class regression against the reference arg-max
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 16; i++) begin
        if (f % 2 == 1) a[i] = int'($urandom_range(0, 6)) - 3;
        else begin r16 = 16'($urandom); a[i] = int'(r16); end
      end
      if (f == 0) for (int i = 0; i < 16; i++) a[i] = -32768;
      if (f == 2) begin a[3] = 32767; a[9] = -32768; end
      tv  = int'($urandom_range(0, 40));
      th2 = tv[16:0];
      for (int i = 0; i < 16; i++) begin
        v2 = 1'b1;
        d2 = a[i][15:0];
        @(posedge clk); #1;
      end
      v2 = 1'b0;
      ref_eval(a, 16, 16, ei, em, eg);
      check("n16_valid", int'(valid_out2), 1);
      check("n16_idx", int'(class_idx2), ei);
      check("n16_max", int'($signed(max_score2)), em);
      check("n16_margin", int'(margin2), eg);
      check("n16_low", int'(low_conf2), int'(eg < tv));
    end
    @(posedge clk); #1;
    check("n16_idle_valid", int'(valid_out2), 0);

    step(1'b0, 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/argmax_stream.md
# argmax_stream

Parametrised streaming arg-max / confidence unit that replaces the fixed 10-class output comparator at the tail of the digit-recognition network. It accepts one signed class score per valid cycle and tracks the running maximum and runner-up without buffering the whole frame. One cycle after the last score of a frame it emits the winning class index, its score, the top-1/top-2 margin, and a low-confidence flag. It accepts back-to-back frames with no dead cycles and supports a mid-frame flush.

## Interface
- NUM_CLASSES, 10, scores per frame (≥1); IDX_W = max(1, clog2(NUM_CLASSES)) is a localparam.
- DATA_W, 12, score width, two's complement.
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_in  in  1  data_in carries the next score of the current frame.
- data_in  in  DATA_W  signed score. Element k of a frame is class k.
- flush  in  1  abandons the frame in progress.
- margin_thresh  in  DATA_W+1  unsigned. Sampled with the last score of each frame.
- busy  out  1  high when at least one score of the current frame has been accepted.
- valid_out  out  1  one-cycle result strobe.
- class_idx  out  IDX_W  index of the winning class.
- max_score  out  DATA_W  signed winning score.
- margin  out  DATA_W+1  unsigned difference max − runner-up.
- low_conf  out  1  asserted when margin < margin_thresh.

## Operation
- Internal state: element counter cnt (0..NUM_CLASSES-1), run_max, run_idx, run_2nd (DATA_W signed), and a registered copy of the threshold.
- First score of a frame (cnt==0, valid_in):
  - run_max ← x
  - run_idx ← 0
  - run_2nd ← most-negative value, −2^(DATA_W-1)
- Later scores, with x = data_in and i = cnt:
  - If x > run_max (strict): run_2nd ← run_max, run_max ← x, run_idx ← i.
  - Else if x > run_2nd: run_2nd ← x.
  - Else: no change.
  - Ties on the maximum resolve to the lowest index. A later tie becomes the runner-up, which gives margin 0.
- Comparisons are signed. margin is computed at DATA_W+1 bits, so no overflow is possible.
- Last score (cnt==NUM_CLASSES-1, valid_in):
  - The result registers load the final max, index, margin, and the low_conf compare against margin_thresh sampled that cycle.
  - The counter returns to 0.
  - The next cycle may carry the first score of the next frame.
- Result outputs hold their values until the next result. valid_out is high only in the cycle after a last score.
- flush: cnt ← 0 and busy ← 0, and the partial frame is discarded.
  - No valid_out is produced for the discarded frame.
  - The result registers keep the previous frame's values.
  - flush together with valid_in: flush wins and the score is dropped.
  - flush in the same cycle as a last score suppresses that result.
- Gaps (valid_in low) inside a frame are allowed for any number of cycles. The state holds.
- NUM_CLASSES==1: every valid score is both first and last. Result is class 0, margin = x + 2^(DATA_W-1).

## Timing
- Reset (rst_n low at a clock edge), all outputs and state cleared:
  - valid_out=0, busy=0, class_idx=0, max_score=0, margin=0, low_conf=0
  - cnt=0, threshold register 0
- Reset mid-frame discards the frame and produces no valid_out.
- Latency: valid_out rises exactly 1 cycle after the clock edge that accepts the last score.
- Throughput: one score per cycle. A frame of N scores gives a result every N cycles when fed continuously.
- busy rises the cycle after the first accepted score. It falls the cycle after the last score or a flush.
- No backpressure. The block is always ready and the upstream layer never stalls on it.

## Test plan
- Frame with scores 3,−7,100,45,99,0,−2048,12,100,5 (N=10, W=12) and thresh=10 -> valid_out 1 cycle after the 10th score, class_idx=2, max_score=100, margin=0, low_conf=1.
- All scores −5 except class 7 = 20, thresh=10 -> class_idx=7, max_score=20, margin=25, low_conf=0. Outputs hold through 5 idle cycles and valid_out stays low.
- Two frames back-to-back with no gap, winners 4 then 9 -> two valid_out pulses exactly 10 cycles apart, with correct indices. Repeat with random valid_in gaps and check that results are identical.
- flush after 6 scores, then a full frame whose winner is class 1 -> exactly one valid_out, class_idx=1. The previous outputs are unchanged until then. Also flush coincident with the 10th score -> no valid_out.
- rst_n low for 1 cycle after 4 scores -> all outputs 0, no valid_out. The next full frame is processed correctly from class 0.
- Instance with NUM_CLASSES=1, DATA_W=8, score −128 -> class_idx=0, margin=0. Random regression at NUM_CLASSES=16, DATA_W=16 checked against a reference argmax with lowest-index ties.
